// File: rtl/riscv_dcache_miss_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_dcache_miss_ctrl
//
// Miss-handling controller between the data cache and the DRAM model. When
// the cache reports a miss, the controller does three things:
//   - it writes the dirty victim block back to DRAM if needed (WB);
//   - it fetches the requested block (RF);
//   - it hands the block to the cache with a one-cycle refill strobe (DONE).
// The core pipeline is stalled for the whole sequence.
//
// Optional feature macro: DCACHE_MISS_TIMEOUT_EN
//   When defined, a watchdog aborts a WB/RF wait after TIMEOUT cycles without
//   mem_ready. It pulses mem_err and returns to IDLE with no refill.
//   When undefined, the FSM waits forever and mem_err is tied low.
//
// Handshake:
//   The cache raises miss_req and holds it, with miss_dirty, miss_addr,
//   victim_addr and victim_data, until miss_done. The request is accepted on
//   the first IDLE cycle that sees miss_req high. miss_req seen while busy
//   (including DONE) is ignored. DRAM requests are level signals (mem_wren /
//   mem_rden) held until the one-cycle mem_ready completion pulse.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   miss_req, miss_dirty       miss request and victim-dirty flag
//   miss_addr, victim_addr     block addresses (fetch / writeback)
//   victim_data                victim block contents
//   mem_rdata, mem_ready       DRAM read data and completion pulse
//   mem_wren, mem_rden         DRAM write / read enables (never both high)
//   mem_addr, mem_wdata        DRAM block address and write data
//   refill_data, refill_we     fetched block and one-cycle line write strobe
//   miss_done                  one-cycle completion, coincident with refill_we
//   stall                      pipeline freeze
//   mem_err                    one-cycle watchdog timeout pulse
//   miss_cnt, wb_cnt           saturating miss / writeback counters
//   dbg_state                  current FSM state (IDLE=0, WB=1, RF=2, DONE=3)
// ----------------------------------------------------------------------------
module riscv_dcache_miss_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 23,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_req,
    input  logic                  miss_dirty,
    input  logic [S_ADDR-1:0]     miss_addr,
    input  logic [S_ADDR-1:0]     victim_addr,
    input  logic [DATA_WIDTH-1:0] victim_data,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [S_ADDR-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] refill_data,
    output logic                  refill_we,
    output logic                  miss_done,
    output logic                  stall,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      miss_cnt,
    output logic [CNT_W-1:0]      wb_cnt,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RF   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [S_ADDR-1:0]     maddr_q, maddr_d;
    logic [S_ADDR-1:0]     vaddr_q, vaddr_d;
    logic [DATA_WIDTH-1:0] vdata_q, vdata_d;
    logic [S_ADDR-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] refill_data_q, refill_data_d;
    logic                  mem_wren_q, mem_wren_d;
    logic                  mem_rden_q, mem_rden_d;
    logic                  refill_we_q, refill_we_d;
    logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]      wb_cnt_q, wb_cnt_d;

`ifdef DCACHE_MISS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            mem_err_q, mem_err_d;
    logic            timeout_hit;

    assign timeout_hit = (wdog_q == WD_W'(TIMEOUT - 1));
`else
    // Without the watchdog a WB/RF wait can never be aborted. TIMEOUT is
    // folded in only so the constant stays tied to the parameter set; the
    // expression is always 0.
    localparam logic timeout_hit = (TIMEOUT < 0);
`endif

    // Next-state and datapath logic
    always_comb begin
        state_d       = state_q;
        maddr_d       = maddr_q;
        vaddr_d       = vaddr_q;
        vdata_d       = vdata_q;
        refill_data_d = refill_data_q;
        miss_cnt_d    = miss_cnt_q;
        wb_cnt_d      = wb_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    maddr_d = miss_addr;
                    vaddr_d = victim_addr;
                    vdata_d = victim_data;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    if (miss_dirty) begin
                        if (wb_cnt_q != '1) wb_cnt_d = wb_cnt_q + CNT_W'(1);
                        state_d = S_WB;
                    end else begin
                        state_d = S_RF;
                    end
                end
            end
            S_WB: begin
                if (mem_ready)        state_d = S_RF;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_RF: begin
                if (mem_ready) begin
                    refill_data_d = mem_rdata;
                    state_d       = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Moore outputs, registered by decoding the next state
        mem_wren_d  = (state_d == S_WB);
        mem_rden_d  = (state_d == S_RF);
        refill_we_d = (state_d == S_DONE);

        // Address/data change only on entry to a memory state and hold otherwise.
        // On WB->RF the miss address comes from the latch. On IDLE->RF maddr_d is
        // already the live input.
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == S_WB && state_q != S_WB) begin
            mem_addr_d  = vaddr_d;
            mem_wdata_d = vdata_d;
        end else if (state_d == S_RF && state_q != S_RF) begin
            mem_addr_d = maddr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            maddr_q       <= '0;
            vaddr_q       <= '0;
            vdata_q       <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            refill_data_q <= '0;
            mem_wren_q    <= 1'b0;
            mem_rden_q    <= 1'b0;
            refill_we_q   <= 1'b0;
            miss_cnt_q    <= '0;
            wb_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            maddr_q       <= maddr_d;
            vaddr_q       <= vaddr_d;
            vdata_q       <= vdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            refill_data_q <= refill_data_d;
            mem_wren_q    <= mem_wren_d;
            mem_rden_q    <= mem_rden_d;
            refill_we_q   <= refill_we_d;
            miss_cnt_q    <= miss_cnt_d;
            wb_cnt_q      <= wb_cnt_d;
        end
    end

`ifdef DCACHE_MISS_TIMEOUT_EN
    // The watchdog restarts at 0 on every entry to WB or RF. It then counts
    // each cycle spent there, so it reads TIMEOUT-1 in the TIMEOUT-th cycle.
    always_comb begin
        wdog_d    = '0;
        mem_err_d = 1'b0;
        if ((state_q == S_WB || state_q == S_RF) && state_d == state_q) begin
            wdog_d = wdog_q + WD_W'(1);
        end
        if ((state_q == S_WB || state_q == S_RF) && !mem_ready && timeout_hit) begin
            mem_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_wren    = mem_wren_q;
    assign mem_rden    = mem_rden_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign refill_data = refill_data_q;
    assign refill_we   = refill_we_q;
    assign miss_done   = refill_we_q;
    assign miss_cnt    = miss_cnt_q;
    assign wb_cnt      = wb_cnt_q;
    assign dbg_state   = state_q;
    // Combinational term so the core freezes in the same cycle the miss is raised
    assign stall       = (state_q != S_IDLE) | miss_req;

endmodule

// File: doc/riscv_dcache_miss_ctrl.md
# riscv_dcache_miss_ctrl

Miss-handling controller sitting between the data cache and the DRAM model. On a cache miss it optionally writes the dirty victim block back to DRAM, then fetches the requested 128-bit block and hands it to the cache for line refill. Meanwhile it holds the pipeline stalled. It owns the DRAM `wren`/`rden`/`addr`/`data_in` request signals and consumes `data_out`/`mem_ready`.

## Interface
Parameters:
- `DATA_WIDTH`, 128: cache block / DRAM word width.
- `S_ADDR`, 23: block address width (byte offset stripped).
- `CNT_W`, 16: width of the statistics counters.
- `TIMEOUT`, 64: watchdog limit in cycles; only used with `DCACHE_MISS_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset. Asserting it clears all state immediately; deassertion is synchronous to `clk`.
- `miss_req` in 1: cache reports a miss. Held high until `miss_done`.
- `miss_dirty` in 1: victim line is dirty; sampled with `miss_req`.
- `miss_addr` in S_ADDR: block address to fetch.
- `victim_addr` in S_ADDR: block address of the victim line.
- `victim_data` in DATA_WIDTH: victim block contents.
- `mem_rdata` in DATA_WIDTH: DRAM `data_out`.
- `mem_ready` in 1: DRAM completion pulse.
- `mem_wren` out 1: DRAM write enable.
- `mem_rden` out 1: DRAM read enable.
- `mem_addr` out S_ADDR: DRAM block address.
- `mem_wdata` out DATA_WIDTH: DRAM write data.
- `refill_data` out DATA_WIDTH: fetched block for the cache.
- `refill_we` out 1: one-cycle cache line write strobe.
- `miss_done` out 1: one-cycle completion pulse, coincident with `refill_we`.
- `stall` out 1: freezes the core pipeline.
- `mem_err` out 1: one-cycle timeout error pulse.
- `miss_cnt` out CNT_W: accepted miss count.
- `wb_cnt` out CNT_W: writeback count.

## Operation
- FSM states: IDLE, WB, RF, DONE (plus the error exit, see Configuration).
- IDLE, with `miss_req`=1: the request is accepted.
  - Latch `miss_addr`, `victim_addr`, and `victim_data`.
  - Increment `miss_cnt`.
  - If `miss_dirty`=1: increment `wb_cnt` and go to WB. Otherwise go to RF.
- WB:
  - Outputs: `mem_wren`=1, `mem_addr`=latched victim address, `mem_wdata`=latched victim data.
  - On `mem_ready`=1, go to RF.
- RF:
  - Outputs: `mem_rden`=1, `mem_addr`=latched miss address.
  - On `mem_ready`=1, register `mem_rdata` into `refill_data` and go to DONE.
- DONE:
  - `refill_we`=1 and `miss_done`=1 for exactly one cycle.
  - Unconditionally return to IDLE.
- Output decoding:
  - `mem_wren`/`mem_rden` are decoded from state only (Moore) and are never both high.
  - `mem_addr`/`mem_wdata` hold their last values when idle.
- `stall` = (state != IDLE) | (state == IDLE & `miss_req`). The core therefore freezes in the same cycle the miss is raised.
- Counters saturate at all-ones and never wrap.
- `refill_data` holds its value until the next RF capture.

## Timing
- Reset values:
  - FSM=IDLE.
  - `mem_wren`, `mem_rden`, `refill_we`, `miss_done`, `mem_err`, `stall` (absent `miss_req`) = 0.
  - `mem_addr`, `mem_wdata`, `refill_data`, `miss_cnt`, `wb_cnt` = 0.
- Let `mem_ready` arrive k cycles after entering a memory state, with k≥1 and k=1 meaning the first state cycle.
  - Clean miss: accept at cycle 0, RF during cycles 1..k, DONE at cycle k+1, IDLE at k+2.
  - Dirty miss: latency increases by the WB residency.
- `mem_ready` is ignored in IDLE and DONE.
- A new `miss_req` while busy is ignored. The cache keeps `miss_req` asserted until `miss_done`. `miss_req` seen in DONE is not re-accepted until the cycle after returning to IDLE.
- Reset asserted mid-operation:
  - Outputs clear asynchronously.
  - The in-flight request is abandoned; no `refill_we` is issued.

## Configuration
- `DCACHE_MISS_TIMEOUT_EN` defined:
  - A watchdog counter clears on every entry to WB or RF and increments each cycle spent there.
  - If it reaches `TIMEOUT`-1 without `mem_ready`, `mem_err` pulses for one cycle and the FSM returns to IDLE.
  - No `refill_we` is issued for that request.
- Macro undefined:
  - The FSM waits indefinitely for `mem_ready`.
  - `mem_err` is tied to 0 and no watchdog logic is present.

## Test plan
- Clean miss, `miss_addr`=0x00010, `mem_ready` on the 3rd RF cycle with `mem_rdata`=0xA5..A5 → `mem_rden` high for 3 cycles, then `refill_we`/`miss_done` pulse once with `refill_data`=0xA5..A5. `miss_cnt`=1, `wb_cnt`=0.
- Dirty miss, `victim_addr`=0x7FFFF, `victim_data`=0x1234 → WB with `mem_wren`=1, `mem_addr`=0x7FFFF, `mem_wdata`=0x1234. Then RF at the miss address. `wb_cnt`=1; `mem_wren` and `mem_rden` are never high together.
- `mem_ready` pulsed in IDLE, and `miss_req` toggled while in RF → no state change and no extra counter increments.
- `rst_n` dropped during WB → `mem_wren`=0 immediately. After reset, `refill_we` never fires for the abandoned request.
- Preload `miss_cnt` near saturation with 65536+ misses under CNT_W=16 → `miss_cnt` holds at 0xFFFF.
- `DCACHE_MISS_TIMEOUT_EN` with `TIMEOUT`=8 and `mem_ready` withheld → `mem_err` pulses once after 8 RF cycles, FSM returns to IDLE, no `refill_we`.
